// File: rtl/dm_access_ctrl.sv
// Load/store access controller between the CPU memory stage and a word-wide
// data memory (2**DM_AW x 32). Byte and halfword stores are done as
// read-modify-write. Loads are sign- or zero-extended. Misaligned, illegal-size
// and out-of-range accesses finish with err and never write memory.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, we, size   request, 1 = store, 00 byte / 01 half / 10 word / 11 illegal
//   sext, addr      load sign-extend select, byte address
//   wdata           store data (sub-word data taken from its low bits)
//   rdata           registered load result, held until the next load completes
//   done, err       one-cycle completion pulse; err qualifies done
//   busy            high whenever the controller is not idle
//   dm_addr, dm_din word address and write data to memory
//   dm_memwr        memory write enable (memory commits on posedge)
//   dm_dout         combinational memory read data for dm_addr
module dm_access_ctrl #(
  parameter int unsigned DM_AW       = 10,
  parameter int unsigned RANGE_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             sext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_memwr,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_e;

  state_e      state_q;
  logic        we_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        memwr_q;

  // Request classification, evaluated on the live inputs in the capture cycle.
  logic range_bad;
  logic req_err;
  logic word_store;

  assign range_bad  = (RANGE_CHECK != 0) && (addr[31:DM_AW+2] != '0);
  assign req_err    = (size == 2'b11) ||
                      ((size == 2'b01) && addr[0]) ||
                      ((size == 2'b10) && (addr[1:0] != 2'b00)) ||
                      range_bad;
  assign word_store = we && (size == 2'b10);

  // Lane extraction for loads and lane merge for sub-word stores.
  logic [4:0]  shamt;
  logic [15:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] load_val;
  logic [31:0] merge_word;

  always_comb begin
    shamt     = {lane_q, 3'b000};
    lane_data = 16'(dm_dout >> shamt);
    load_val  = dm_dout;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        load_val  = {{24{sext_q & lane_data[7]}}, lane_data[7:0]};
        lane_mask = 32'h0000_00FF;
      end
      2'b01: begin
        load_val  = {{16{sext_q & lane_data[15]}}, lane_data[15:0]};
        lane_mask = 32'h0000_FFFF;
      end
      default: ;
    endcase
    merge_word = (dm_dout & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
  end

  // Gate with rst so a write in flight cannot commit on the reset edge.
  assign dm_memwr = memwr_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      memwr_q <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      dm_addr <= '0;
      dm_din  <= '0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      memwr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            sext_q  <= sext;
            size_q  <= size;
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (req_err) begin
              state_q <= StErr;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              dm_addr <= addr[DM_AW+1:2];
              if (word_store) begin
                state_q <= StWr;
                dm_din  <= wdata;
                memwr_q <= 1'b1;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (we_q) begin
            // Old word is merged here so WR only has to drive the write.
            state_q <= StWr;
            dm_din  <= merge_word;
            memwr_q <= 1'b1;
          end else begin
            state_q <= StDone;
            rdata   <= load_val;
            done    <= 1'b1;
          end
        end
        StWr: begin
          state_q <= StDone;
          done    <= 1'b1;
        end
        StDone, StErr: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, dm_din, dm_dout;
  logic        done, err, busy, dm_memwr;
  logic [9:0]  dm_addr;

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rdata;
  int          wr_cnt = 0;
  logic [9:0]  last_wa;
  logic [31:0] last_din;
  int          vectors = 0;
  int          miscompares = 0;

  dm_access_ctrl #(.DM_AW(10), .RANGE_CHECK(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .dm_addr(dm_addr), .dm_din(dm_din), .dm_memwr(dm_memwr),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Memory behind the controller: combinational read, posedge write.
  assign dm_dout = tb_mem[dm_addr];
  always @(posedge clk) begin
    if (dm_memwr) begin
      tb_mem[dm_addr] <= dm_din;
      wr_cnt          <= wr_cnt + 1;
      last_wa         <= dm_addr;
      last_din        <= dm_din;
    end
  end

  // Reference model: byte-granular view of memory, one call per transaction.
  task automatic model_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e, output int nwr);
    int nb, base;
    logic [31:0] word, val;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e   = (sz == 2'd3) || ((a % nb) != 0) || (a > 32'hFFF);
    nwr = 0;
    lat = 1;
    if (!e) begin
      word = ref_mem[a[11:2]];
      base = int'(a[1:0]);
      if (!w) begin
        lat = 2;
        val = '0;
        for (int k = 0; k < nb; k++) val[8*k +: 8] = word[8*(base+k) +: 8];
        if (sx && nb < 4 && val[8*nb-1])
          for (int k = nb; k < 4; k++) val[8*k +: 8] = 8'hFF;
        ref_rdata = val;
      end else begin
        lat = (nb == 4) ? 2 : 3;
        nwr = 1;
        for (int k = 0; k < nb; k++) word[8*(base+k) +: 8] = wd[8*k +: 8];
        ref_mem[a[11:2]] = word;
      end
    end
  endtask

  // Drives one request and measures it. lat counts edges, the sampling edge being 1.
  task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output int nwr, output logic dn_after);
    int w0;
    w0 = wr_cnt;
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    lat = -1;
    e   = 1'bx;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (done) begin
        lat = i;
        e   = err;
      end
    end
    nwr = wr_cnt - w0;
    @(posedge clk); #1;
    dn_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0;
    addr = 32'h0; wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    vectors++; if ({done, err, busy, dm_memwr} !== 4'b0) begin miscompares++;
      $display("FAIL reset_flags: got done/err/busy/memwr=%b want 0000", {done, err, busy, dm_memwr}); end
    vectors++; if (dm_addr !== 10'h0 || dm_din !== 32'h0) begin miscompares++;
      $display("FAIL reset_dm_bus: got addr=%h din=%h want 0/0", dm_addr, dm_din); end
    req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (tb_mem[0] !== ref_mem[0] || wr_cnt !== 0) begin miscompares++;
      $display("FAIL reset_req_dropped: got mem0=%h writes=%0d want %h 0", tb_mem[0], wr_cnt, ref_mem[0]); end
    ref_rdata = 32'h0;
  endtask

  task automatic test_word();
    int lat, nwr, xl, xn;
    logic e, dn, xe;
    run_op(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, lat, e, nwr, dn);
    model_op(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, xl, xe, xn);
    vectors++; if (lat !== 2 || e !== 1'b0) begin miscompares++; $display("FAIL sw_timing: got lat=%0d err=%b want 2 0", lat, e); end
    vectors++; if (nwr !== 1 || last_wa !== 10'd4 || last_din !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL sw_write: got n=%0d addr=%0d din=%h want 1 4 deadbeef", nwr, last_wa, last_din); end
    vectors++; if (dn !== 1'b0) begin miscompares++; $display("FAIL sw_done_pulse: got %b want 0", dn); end
    run_op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, e, nwr, dn);
    model_op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, xl, xe, xn);
    vectors++; if (lat !== 2 || nwr !== 0) begin miscompares++; $display("FAIL lw_timing: got lat=%0d n=%0d want 2 0", lat, nwr); end
    vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data: got %h want deadbeef", rdata); end
  endtask

  task automatic test_subword();
    int lat, nwr, xl, xn;
    logic e, dn, xe;
    tb_mem[4] <= 32'h11223344;
    ref_mem[4] = 32'h11223344;
    run_op(1'b1, 2'b00, 1'b0, 32'h011, 32'h000000AA, lat, e, nwr, dn);
    model_op(1'b1, 2'b00, 1'b0, 32'h011, 32'h000000AA, xl, xe, xn);
    vectors++; if (lat !== 3 || e !== 1'b0) begin miscompares++; $display("FAIL sb_timing: got lat=%0d err=%b want 3 0", lat, e); end
    vectors++; if (nwr !== 1 || last_din !== 32'h1122AA44) begin miscompares++;
      $display("FAIL sb_merge: got n=%0d din=%h want 1 1122aa44", nwr, last_din); end
  endtask

  task automatic test_load_ext();
    int lat, nwr, xl, xn;
    logic e, dn, xe;
    tb_mem[4] <= 32'h80FF0000; ref_mem[4] = 32'h80FF0000;
    tb_mem[0] <= 32'h80FF0000; ref_mem[0] = 32'h80FF0000;
    run_op(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, lat, e, nwr, dn);
    model_op(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, xl, xe, xn);
    vectors++; if (rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_sext: got %h want ffffff80", rdata); end
    run_op(1'b0, 2'b00, 1'b0, 32'h013, 32'h0, lat, e, nwr, dn);
    model_op(1'b0, 2'b00, 1'b0, 32'h013, 32'h0, xl, xe, xn);
    vectors++; if (rdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu_zext: got %h want 00000080", rdata); end
    run_op(1'b0, 2'b01, 1'b0, 32'h002, 32'h0, lat, e, nwr, dn);
    model_op(1'b0, 2'b01, 1'b0, 32'h002, 32'h0, xl, xe, xn);
    vectors++; if (rdata !== 32'h000080FF) begin miscompares++; $display("FAIL lhu_zext: got %h want 000080ff", rdata); end
  endtask

  task automatic test_errors();
    int lat, nwr, xl, xn;
    logic e, dn, xe;
    logic        ew   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  esz  [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] eadr [4] = '{32'h003, 32'h002, 32'h000, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      run_op(ew[i], esz[i], 1'b1, eadr[i], 32'h5A5A5A5A, lat, e, nwr, dn);
      model_op(ew[i], esz[i], 1'b1, eadr[i], 32'h5A5A5A5A, xl, xe, xn);
      vectors++; if (lat !== 1 || e !== 1'b1) begin miscompares++;
        $display("FAIL err_case%0d_timing: got lat=%0d err=%b want 1 1", i, lat, e); end
      vectors++; if (nwr !== 0 || rdata !== 32'h000080FF) begin miscompares++;
        $display("FAIL err_case%0d_effect: got n=%0d rdata=%h want 0 000080ff", i, nwr, rdata); end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [31:0] old;
    logic seen_done;
    old = ref_mem[8];
    w0  = wr_cnt;
    we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h020; wdata = 32'h00000055; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dm_memwr !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_wr: got memwr=%b want 1", dm_memwr); end
    rst = 1'b1;
    #1;
    vectors++; if (dm_memwr !== 1'b0) begin miscompares++; $display("FAIL rstmid_gate: got memwr=%b want 0", dm_memwr); end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_idle: got busy=%b done=%b want 0 0", busy, done); end
    seen_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
    vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_done: got done pulse want none"); end
    vectors++; if (wr_cnt !== w0 || tb_mem[8] !== old) begin miscompares++;
      $display("FAIL rstmid_mem: got n=%0d word=%h want 0 %h", wr_cnt - w0, tb_mem[8], old); end
    ref_rdata = 32'h0;
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_back_to_back();
    int w0, first, second, xl, xn;
    logic xe, idle_seen;
    w0 = wr_cnt;
    we = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h032; wdata = 32'h1234ABCD; req = 1'b1;
    model_op(1'b1, 2'b01, 1'b0, 32'h032, 32'h1234ABCD, xl, xe, xn);
    first = -1;
    for (int i = 1; i <= 10 && first < 0; i++) begin @(posedge clk); #1; if (done) first = i; end
    vectors++; if (first !== 3 || wr_cnt - w0 !== 1) begin miscompares++;
      $display("FAIL b2b_first: got lat=%0d n=%0d want 3 1", first, wr_cnt - w0); end
    // Keep req high and switch to a load: it must wait for the idle cycle.
    we = 1'b0; size = 2'b10; addr = 32'h030;
    model_op(1'b0, 2'b10, 1'b0, 32'h030, 32'h0, xl, xe, xn);
    second = -1; idle_seen = 1'b0;
    for (int i = 1; i <= 10 && second < 0; i++) begin
      @(posedge clk); #1;
      if (!busy) idle_seen = 1'b1;
      else if (idle_seen) req = 1'b0;
      if (done) second = i;
    end
    req = 1'b0;
    vectors++; if (second !== 3 || wr_cnt - w0 !== 1) begin miscompares++;
      $display("FAIL b2b_second: got gap=%0d n=%0d want 3 1", second, wr_cnt - w0); end
    vectors++; if (rdata !== ref_rdata || rdata[31:16] !== 16'hABCD) begin miscompares++;
      $display("FAIL b2b_rdata: got %h want %h", rdata, ref_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, nwr, xl, xn;
    logic e, dn, xe, w, sx;
    logic [1:0] sz;
    logic [31:0] a, wd;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
      wd = $urandom;
      run_op(w, sz, sx, a, wd, lat, e, nwr, dn);
      model_op(w, sz, sx, a, wd, xl, xe, xn);
      vectors++; if (lat !== xl || e !== xe) begin miscompares++;
        $display("FAIL rnd%0d_timing: got lat=%0d err=%b want %0d %b (we=%b sz=%0d a=%h)", n, lat, e, xl, xe, w, sz, a); end
      vectors++; if (nwr !== xn) begin miscompares++; $display("FAIL rnd%0d_writes: got %0d want %0d", n, nwr, xn); end
      vectors++; if (rdata !== ref_rdata) begin miscompares++;
        $display("FAIL rnd%0d_rdata: got %h want %h (sz=%0d sext=%b a=%h)", n, rdata, ref_rdata, sz, sx, a); end
      vectors++; if (tb_mem[a[11:2]] !== ref_mem[a[11:2]]) begin miscompares++;
        $display("FAIL rnd%0d_mem: got %h want %h (sz=%0d a=%h)", n, tb_mem[a[11:2]], ref_mem[a[11:2]], sz, a); end
      vectors++; if (dn !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_done_pulse: got %b want 0", n, dn); end
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      tb_mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_word();
    test_subword();
    test_load_ext();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
